// File: rtl/surf_dna_seq_pkg.sv
// Shared types and constants for the device-DNA readout sequencer.
package surf_dna_seq_pkg;

    localparam int          DNA_BITS  = 96;
    localparam logic [10:0] DNA_ADDR  = 11'h008;
    localparam logic [31:0] LOAD_WORD = 32'h8000_0000;

    typedef enum logic [2:0] {
        IDLE,
        LOAD,
        READ,
        GAP,
        DONE
    } state_t;

endpackage

// File: rtl/surf_dna_seq_if.sv
// Wishbone master-side bundle between the DNA sequencer and the ID/control interconnect.
interface surf_dna_seq_if #(
    parameter int ADR_BITS = 11
);
    logic                wbm_cyc_o;
    logic                wbm_stb_o;
    logic                wbm_we_o;
    logic [ADR_BITS-1:0] wbm_adr_o;
    logic [31:0]         wbm_dat_o;
    logic [3:0]          wbm_sel_o;
    logic                wbm_ack_i;
    logic                wbm_err_i;
    logic [31:0]         wbm_dat_i;

    modport master (
        output wbm_cyc_o, wbm_stb_o, wbm_we_o, wbm_adr_o, wbm_dat_o, wbm_sel_o,
        input  wbm_ack_i, wbm_err_i, wbm_dat_i
    );

    modport slave (
        input  wbm_cyc_o, wbm_stb_o, wbm_we_o, wbm_adr_o, wbm_dat_o, wbm_sel_o,
        output wbm_ack_i, wbm_err_i, wbm_dat_i
    );
endinterface

// File: rtl/surf_dna_seq_xfer.sv
// Single wishbone transaction with a saturating ack timeout; cyc/stb drop on the edge that ends it.
module wb_single_xfer #(
    parameter int                  ADR_BITS = 11,
    parameter logic [ADR_BITS-1:0] ADDR     = '0,
    parameter int                  TIMEOUT  = 255
) (
    input  logic           wb_clk_i,
    input  logic           wb_rst_n_i,
    input  logic           start_i,
    input  logic           we_i,
    input  logic [31:0]    dat_i,
    input  logic [3:0]     sel_i,
    output logic           done_o,
    output logic           err_o,
    output logic [31:0]    rdata_o,
    surf_dna_seq_if.master wbm
);
    logic        r_stb;
    logic        r_we;
    logic [31:0] r_dat;
    logic [3:0]  r_sel;
    logic [7:0]  r_wait;
    logic        w_timeout;

    // err on the bus beats a simultaneous ack; timeout only fires when no ack arrived
    assign w_timeout = (r_wait == 8'(TIMEOUT));
    assign err_o     = r_stb & (wbm.wbm_err_i | (w_timeout & ~wbm.wbm_ack_i));
    assign done_o    = r_stb & wbm.wbm_ack_i & ~wbm.wbm_err_i;
    assign rdata_o   = wbm.wbm_dat_i;

    always_ff @(posedge wb_clk_i or negedge wb_rst_n_i) begin
        if (!wb_rst_n_i) begin
            r_stb  <= 1'b0;
            r_we   <= 1'b0;
            r_dat  <= '0;
            r_sel  <= '0;
            r_wait <= '0;
        end else if (start_i) begin
            r_stb  <= 1'b1;
            r_we   <= we_i;
            r_dat  <= dat_i;
            r_sel  <= sel_i;
            r_wait <= '0;
        end else if (done_o || err_o) begin
            r_stb  <= 1'b0;
            r_we   <= 1'b0;
            r_dat  <= '0;
            r_sel  <= '0;
        end else if (r_stb && (r_wait != 8'hFF)) begin
            r_wait <= r_wait + 8'd1;
        end
    end

    assign wbm.wbm_cyc_o = r_stb;
    assign wbm.wbm_stb_o = r_stb;
    assign wbm.wbm_we_o  = r_we;
    assign wbm.wbm_adr_o = ADDR;
    assign wbm.wbm_dat_o = r_dat;
    assign wbm.wbm_sel_o = r_sel;

endmodule

// File: rtl/surf_dna_sequencer.sv
// Reads the device DNA through the ID/control DNA register: one LOAD write, then one read per bit.
// state | meaning
// IDLE  | waiting for start_i
// LOAD  | write LOAD_WORD to latch the DNA shift register
// READ  | read one DNA bit (bit 0 of the read data)
// GAP   | one cycle with cyc low before the next read
// DONE  | one-cycle completion pulse
module surf_dna_sequencer #(
    parameter int                     DNA_BITS    = surf_dna_seq_pkg::DNA_BITS,
    parameter int                     WB_ADR_BITS = 11,
    parameter logic [WB_ADR_BITS-1:0] DNA_ADDR    = surf_dna_seq_pkg::DNA_ADDR,
    parameter int                     TIMEOUT     = 255
) (
    input  logic                wb_clk_i,
    input  logic                wb_rst_n_i,
    input  logic                start_i,
    output logic                busy_o,
    output logic                done_o,
    output logic                err_o,
    output logic                dna_valid_o,
    output logic [DNA_BITS-1:0] dna_o,
    surf_dna_seq_if.master      wbm
);
    import surf_dna_seq_pkg::*;

    localparam logic [6:0] LAST_BIT = 7'(DNA_BITS - 1);

    state_t              r_state;
    state_t              w_state_nxt;
    logic [6:0]          r_bit_cnt;
    logic                r_err;
    logic                r_dna_valid;
    logic [DNA_BITS-1:0] r_dna;
    logic                w_xfer_start;
    logic                w_xfer_we;
    logic [31:0]         w_xfer_dat;
    logic [3:0]          w_xfer_sel;
    logic                w_xfer_done;
    logic                w_xfer_err;
    logic [31:0]         w_xfer_rdata;
    logic                w_last_bit;
    logic                w_unused_rdata;

    assign w_last_bit     = (r_bit_cnt == LAST_BIT);
    assign w_unused_rdata = ^w_xfer_rdata[31:1];

    always_ff @(posedge wb_clk_i or negedge wb_rst_n_i) begin
        if (!wb_rst_n_i) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            IDLE: if (start_i) w_state_nxt = LOAD;
            LOAD: begin
                if (w_xfer_err)       w_state_nxt = DONE;
                else if (w_xfer_done) w_state_nxt = GAP;
            end
            READ: begin
                if (w_xfer_err)       w_state_nxt = DONE;
                else if (w_xfer_done) w_state_nxt = w_last_bit ? DONE : GAP;
            end
            GAP:     w_state_nxt = READ;
            DONE:    w_state_nxt = IDLE;
            default: w_state_nxt = IDLE;
        endcase
    end

    // transactions are launched on the edge that enters LOAD/READ so stb is registered
    always_comb begin
        w_xfer_start = 1'b0;
        w_xfer_we    = 1'b0;
        w_xfer_dat   = '0;
        w_xfer_sel   = '0;
        case (r_state)
            IDLE: begin
                if (start_i) begin
                    w_xfer_start = 1'b1;
                    w_xfer_we    = 1'b1;
                    w_xfer_dat   = LOAD_WORD;
                    w_xfer_sel   = 4'b1000;
                end
            end
            GAP: begin
                w_xfer_start = 1'b1;
                w_xfer_sel   = 4'b1111;
            end
            default: ;
        endcase
    end

    always_ff @(posedge wb_clk_i or negedge wb_rst_n_i) begin
        if (!wb_rst_n_i) begin
            r_bit_cnt   <= '0;
            r_err       <= 1'b0;
            r_dna_valid <= 1'b0;
            r_dna       <= '0;
        end else begin
            case (r_state)
                IDLE: begin
                    if (start_i) begin
                        r_bit_cnt   <= '0;
                        r_err       <= 1'b0;
                        r_dna_valid <= 1'b0;
                        r_dna       <= '0;
                    end
                end
                LOAD: if (w_xfer_err) r_err <= 1'b1;
                READ: begin
                    if (w_xfer_err) begin
                        r_err <= 1'b1;
                    end else if (w_xfer_done) begin
                        r_dna <= {w_xfer_rdata[0], r_dna[DNA_BITS-1:1]};
                        if (w_last_bit) r_dna_valid <= 1'b1;
                        else            r_bit_cnt   <= r_bit_cnt + 7'd1;
                    end
                end
                default: ;
            endcase
        end
    end

    wb_single_xfer #(
        .ADR_BITS (WB_ADR_BITS),
        .ADDR     (DNA_ADDR),
        .TIMEOUT  (TIMEOUT)
    ) u_xfer (
        .wb_clk_i   (wb_clk_i),
        .wb_rst_n_i (wb_rst_n_i),
        .start_i    (w_xfer_start),
        .we_i       (w_xfer_we),
        .dat_i      (w_xfer_dat),
        .sel_i      (w_xfer_sel),
        .done_o     (w_xfer_done),
        .err_o      (w_xfer_err),
        .rdata_o    (w_xfer_rdata),
        .wbm        (wbm)
    );

    assign busy_o      = (r_state == LOAD) || (r_state == READ) || (r_state == GAP);
    assign done_o      = (r_state == DONE);
    assign err_o       = r_err;
    assign dna_valid_o = r_dna_valid;
    assign dna_o       = r_dna;

endmodule

// File: tb/tb_surf_dna_sequencer.sv
// Bench for surf_dna_sequencer: wishbone slave model, scoreboard of expected readout results.
module tb_surf_dna_sequencer;

    localparam logic [10:0]  ADDR     = 11'h008;
    localparam logic [95:0]  DNA_FIX  = 96'h0123_4567_89AB_CDEF_0011_2233;

    typedef struct {
        logic        err;
        logic        valid;
        logic [95:0] dna;
        int          reads;
        int          writes;
        int          lat;
        int          start_edge;
    } exp_t;

    logic        wb_clk_i   = 1'b0;
    logic        wb_rst_n_i = 1'b0;
    logic        start_i    = 1'b0;
    logic        busy_o;
    logic        done_o;
    logic        err_o;
    logic        dna_valid_o;
    logic [95:0] dna_o;

    surf_dna_seq_if #(.ADR_BITS(11)) bus ();

    surf_dna_sequencer #(
        .DNA_BITS    (96),
        .WB_ADR_BITS (11),
        .DNA_ADDR    (ADDR),
        .TIMEOUT     (255)
    ) dut (
        .wb_clk_i    (wb_clk_i),
        .wb_rst_n_i  (wb_rst_n_i),
        .start_i     (start_i),
        .busy_o      (busy_o),
        .done_o      (done_o),
        .err_o       (err_o),
        .dna_valid_o (dna_valid_o),
        .dna_o       (dna_o),
        .wbm         (bus)
    );

    always #5 wb_clk_i = ~wb_clk_i;

    int edge_cnt = 0;
    always @(posedge wb_clk_i) edge_cnt <= edge_cnt + 1;

    int          n_cmp = 0;
    int          n_bad = 0;
    exp_t        sb[$];
    logic [95:0] slv_dna      = '0;
    bit          slv_rand_lat = 1'b0;
    int          slv_hang_idx = -1;
    bit          slv_err_load = 1'b0;
    int          rd_idx       = 0;
    int          n_reads      = 0;
    int          n_writes     = 0;

    task automatic chk(input string nm, input logic [95:0] act, input logic [95:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h, want %0h", nm, act, exp);
        end
    endtask

    // after n bits have shifted in from the top, bit j of the DNA sits at position 96-n+j
    function automatic logic [95:0] ref_dna(input logic [95:0] dna, input int nbits);
        logic [95:0] mask;
        if (nbits <= 0)  return '0;
        if (nbits >= 96) return dna;
        mask = (96'd1 << nbits) - 96'd1;
        return (dna & mask) << (96 - nbits);
    endfunction

    // slave: one registered ack per access, bit k of the DNA on read k after each LOAD
    initial begin
        bit          is_wr;
        int          lat;
        int          len;
        logic [31:0] rnd;
        bus.wbm_ack_i = 1'b0;
        bus.wbm_err_i = 1'b0;
        bus.wbm_dat_i = '0;
        forever begin
            @(negedge wb_clk_i);
            if (bus.wbm_cyc_o && bus.wbm_stb_o) begin
                is_wr = bus.wbm_we_o;
                chk("adr", 96'(bus.wbm_adr_o), 96'(ADDR));
                if (is_wr) begin
                    n_writes++;
                    rd_idx = 0;
                    chk("load_sel", 96'(bus.wbm_sel_o), 96'(4'b1000));
                    chk("load_dat", 96'(bus.wbm_dat_o), 96'(32'h8000_0000));
                end else begin
                    n_reads++;
                    chk("read_sel", 96'(bus.wbm_sel_o), 96'(4'b1111));
                    chk("read_dat", 96'(bus.wbm_dat_o), 96'd0);
                end
                if (!is_wr && rd_idx == slv_hang_idx) begin
                    len = 0;
                    while (bus.wbm_stb_o && len < 1000) begin
                        len++;
                        @(negedge wb_clk_i);
                    end
                    n_cmp++;
                    if (len < 255 || len > 257) begin
                        n_bad++;
                        $display("FAIL timeout_len: got %0d stb cycles, want 255..257", len);
                    end
                end else begin
                    lat = slv_rand_lat ? int'($urandom_range(20, 1)) : 1;
                    repeat (lat) @(posedge wb_clk_i);
                    #1;
                    bus.wbm_ack_i = 1'b1;
                    bus.wbm_err_i = is_wr && slv_err_load;
                    if (!is_wr) begin
                        rnd = $urandom;
                        rnd[0] = slv_dna[rd_idx % 96];
                        bus.wbm_dat_i = rnd;
                        rd_idx++;
                    end
                    @(posedge wb_clk_i);
                    #1;
                    bus.wbm_ack_i = 1'b0;
                    bus.wbm_err_i = 1'b0;
                    bus.wbm_dat_i = '0;
                    @(negedge wb_clk_i);
                    chk("gap_cyc", 96'(bus.wbm_cyc_o), 96'd0);
                end
            end
        end
    end

    // monitor: every done_o pulse is matched against the oldest expected readout
    initial begin
        exp_t m;
        forever begin
            @(negedge wb_clk_i);
            if (done_o === 1'b1) begin
                if (sb.size() == 0) begin
                    n_cmp++;
                    n_bad++;
                    $display("FAIL unexpected_done: got done_o=1, want no pulse");
                end else begin
                    m = sb.pop_front();
                    chk("done_err", 96'(err_o), 96'(m.err));
                    chk("done_valid", 96'(dna_valid_o), 96'(m.valid));
                    chk("done_dna", dna_o, m.dna);
                    chk("n_reads", 96'(n_reads), 96'(m.reads));
                    chk("n_writes", 96'(n_writes), 96'(m.writes));
                    chk("busy_at_done", 96'(busy_o), 96'd0);
                    if (m.lat >= 0) chk("done_cycle", 96'(edge_cnt - m.start_edge + 1), 96'(m.lat));
                    n_reads  = 0;
                    n_writes = 0;
                end
            end
        end
    end

    task automatic wait_idle();
        int t = 0;
        while ((busy_o || done_o) && t < 8000) begin
            @(negedge wb_clk_i);
            t++;
        end
        n_cmp++;
        if (busy_o || done_o) begin
            n_bad++;
            $display("FAIL idle_wait: got busy_o=%0b after %0d cycles, want 0", busy_o, t);
        end
    endtask

    task automatic wait_sb_empty(input string tag);
        int t = 0;
        while (sb.size() != 0 && t < 8000) begin
            @(negedge wb_clk_i);
            #1;
            t++;
        end
        n_cmp++;
        if (sb.size() != 0) begin
            n_bad++;
            $display("FAIL %s_done_wait: got no done_o in %0d cycles, want a done pulse", tag, t);
            sb.delete();
        end
    endtask

    task automatic build_exp(input logic [95:0] dna, input int hang, input bit err_load,
                             input int lat, output exp_t e);
        int nb;
        nb       = err_load ? 0 : ((hang >= 0) ? hang : 96);
        e.err    = (hang >= 0) || err_load;
        e.valid  = !e.err;
        e.dna    = ref_dna(dna, nb);
        e.reads  = err_load ? 0 : ((hang >= 0) ? hang + 1 : 96);
        e.writes = 1;
        e.lat    = lat;
        e.start_edge = 0;
    endtask

    task automatic accept_start(inout exp_t e, input bit keep_high);
        @(posedge wb_clk_i);
        #1;
        start_i = 1'b1;
        @(posedge wb_clk_i);
        #1;
        start_i = keep_high;
        e.start_edge = edge_cnt;
        sb.push_back(e);
        chk("start_clr_err", 96'(err_o), 96'd0);
        chk("start_clr_valid", 96'(dna_valid_o), 96'd0);
        chk("start_clr_dna", dna_o, 96'd0);
    endtask

    task automatic run(input string tag, input logic [95:0] dna, input bit rand_lat,
                       input int hang, input bit err_load, input int lat);
        exp_t e;
        slv_dna      = dna;
        slv_rand_lat = rand_lat;
        slv_hang_idx = hang;
        slv_err_load = err_load;
        build_exp(dna, hang, err_load, lat, e);
        wait_idle();
        accept_start(e, 1'b0);
        wait_sb_empty(tag);
        repeat (5) @(negedge wb_clk_i);
        chk({tag, "_hold_dna"}, dna_o, e.dna);
        chk({tag, "_hold_valid"}, 96'(dna_valid_o), 96'(e.valid));
        chk({tag, "_hold_err"}, 96'(err_o), 96'(e.err));
    endtask

    task automatic chk_all_zero(input string tag);
        chk({tag, "_busy"}, 96'(busy_o), 96'd0);
        chk({tag, "_done"}, 96'(done_o), 96'd0);
        chk({tag, "_err"}, 96'(err_o), 96'd0);
        chk({tag, "_valid"}, 96'(dna_valid_o), 96'd0);
        chk({tag, "_dna"}, dna_o, 96'd0);
        chk({tag, "_cyc"}, 96'(bus.wbm_cyc_o), 96'd0);
        chk({tag, "_stb"}, 96'(bus.wbm_stb_o), 96'd0);
        chk({tag, "_we"}, 96'(bus.wbm_we_o), 96'd0);
        chk({tag, "_sel"}, 96'(bus.wbm_sel_o), 96'd0);
        chk({tag, "_dat"}, 96'(bus.wbm_dat_o), 96'd0);
    endtask

    initial begin
        bit   quiet;
        exp_t e;

        repeat (3) @(negedge wb_clk_i);
        chk_all_zero("rst");
        chk("rst_adr", 96'(bus.wbm_adr_o), 96'(ADDR));
        wb_rst_n_i = 1'b1;

        quiet = 1'b1;
        for (int i = 0; i < 1000; i++) begin
            @(negedge wb_clk_i);
            if (busy_o || done_o || err_o || dna_valid_o || (dna_o != '0) || bus.wbm_cyc_o || bus.wbm_stb_o)
                quiet = 1'b0;
        end
        chk("idle_quiet", 96'(quiet), 96'd1);

        run("nominal", DNA_FIX, 1'b0, -1, 1'b0, 291);
        run("hang10", {$urandom, $urandom, $urandom}, 1'b0, 10, 1'b0, -1);
        run("after_hang", {$urandom, $urandom, $urandom}, 1'b0, -1, 1'b0, 291);
        run("load_err", {$urandom, $urandom, $urandom}, 1'b0, -1, 1'b1, 3);
        run("after_err", DNA_FIX, 1'b0, -1, 1'b0, 291);

        // start held high: one readout, an automatic second one, then reset mid-readout
        slv_dna      = {$urandom, $urandom, $urandom};
        slv_rand_lat = 1'b0;
        slv_hang_idx = -1;
        slv_err_load = 1'b0;
        build_exp(slv_dna, -1, 1'b0, 291, e);
        wait_idle();
        accept_start(e, 1'b1);
        wait_sb_empty("held_start");
        @(negedge wb_clk_i);
        chk("held_idle_gap", 96'(busy_o), 96'd0);
        @(negedge wb_clk_i);
        chk("held_restart", 96'(busy_o), 96'd1);
        repeat (98) @(posedge wb_clk_i);
        #1;
        wb_rst_n_i = 1'b0;
        #1;
        chk_all_zero("midrst");
        start_i = 1'b0;
        repeat (3) @(negedge wb_clk_i);
        wb_rst_n_i = 1'b1;
        repeat (5) @(negedge wb_clk_i);
        n_reads  = 0;
        n_writes = 0;
        run("after_rst", {$urandom, $urandom, $urandom}, 1'b0, -1, 1'b0, 291);

        run("rand_lat_a", {$urandom, $urandom, $urandom}, 1'b1, -1, 1'b0, -1);
        run("rand_lat_b", {$urandom, $urandom, $urandom}, 1'b1, -1, 1'b0, -1);

        repeat (5) @(negedge wb_clk_i);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
